// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and
// image size limits.
package imem_pkg;
    localparam int MAX_WORDS = 256;
    localparam int HDR_BYTES = 2;
    localparam int HDR_W     = 8 * HDR_BYTES;
    localparam int AW        = $clog2(MAX_WORDS);
    // One extra bit so a full 256-word image can be counted.
    localparam int WIDX_W    = AW + 1;

    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, DATA, LAST, DONE, ERR
    } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// slave is the loader side, master is the host/memory side.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );
    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Shifts big-endian bytes into a 32-bit word; fill flags the byte that
// completes a word, word_full pulses the cycle after with the packed word.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  din,
    output logic        fill,
    output logic        word_full,
    output logic [31:0] word
);
    logic [23:0] sh;
    logic [1:0]  cnt;

    assign fill = push && (cnt == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh        <= '0;
            cnt       <= '0;
            word      <= '0;
            word_full <= 1'b0;
        end else begin
            word_full <= fill;
            if (clr) begin
                cnt <= '0;
            end else if (push) begin
                cnt <= cnt + 2'd1;
                // word only moves on a completed word, so it holds between writes
                if (fill) word <= {sh, din};
                else      sh   <= {sh[15:0], din};
            end
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: reads a 2-byte word count then the image bytes, writes them
// into instruction memory and holds the CPU in reset until the load finishes.
module imem_loader
    import imem_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);
    state_t            state;
    logic [HDR_W-1:0]  count;
    logic [HDR_W-1:0]  hdr_count;
    logic [WIDX_W-1:0] word_idx;
    logic              in_ready_q;
    logic [31:0]       wr_addr_q;
    logic              acc;
    logic              push;
    logic              clr;
    logic              fill;
    logic              last_word;
    logic              pk_full;
    logic [31:0]       pk_word;

    assign acc       = bus.in_valid & in_ready_q;
    assign push      = acc & (state == DATA);
    assign clr       = start & (state == IDLE || state == DONE || state == ERR);
    assign hdr_count = {count[HDR_W-1:8], bus.in_data};
    assign last_word = ({{(HDR_W-WIDX_W){1'b0}}, word_idx} == count - HDR_W'(1));

    byte_packer u_pack (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .push      (push),
        .din       (bus.in_data),
        .fill      (fill),
        .word_full (pk_full),
        .word      (pk_word)
    );

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = pk_full;
    assign bus.wr_data  = pk_word;
    assign bus.wr_addr  = wr_addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cpu_hold   <= 1'b1;
            in_ready_q <= 1'b0;
            wr_addr_q  <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_idx   <= '0;
            count      <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= HDR0;
                        in_ready_q <= 1'b1;
                        word_idx   <= '0;
                        count      <= '0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        cpu_hold   <= 1'b1;
                    end
                end
                HDR0: begin
                    if (acc) begin
                        count[HDR_W-1:8] <= bus.in_data;
                        state            <= HDR1;
                    end
                end
                HDR1: begin
                    if (acc) begin
                        count <= hdr_count;
                        if (hdr_count == '0) begin
                            state      <= DONE;
                            in_ready_q <= 1'b0;
                            done       <= 1'b1;
                            cpu_hold   <= 1'b0;
                        end else if (hdr_count > HDR_W'(MAX_WORDS)) begin
                            state      <= ERR;
                            in_ready_q <= 1'b0;
                            error      <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    // Address is captured with the word so it lines up with wr_en.
                    if (fill) begin
                        wr_addr_q <= {{(30-AW){1'b0}}, word_idx[AW-1:0], 2'b00};
                        word_idx  <= word_idx + 1'b1;
                        if (last_word) begin
                            state      <= LAST;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                LAST: begin
                    state    <= DONE;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed checks of imem_loader against an image-level model:
// the expected write list is derived directly from the header and byte stream.
module tb_imem_loader;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, done, error;

    imem_loader_if bus();

    imem_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_acc = 0;
    wr_t         obs_q[$];
    logic [63:0] exp_q[$];
    logic [7:0]  img[$];
    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) n_acc <= n_acc + 1;
    end

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            obs_q.push_back('{bus.wr_addr, bus.wr_data, cyc});
            mem[bus.wr_addr[9:2]] = bus.wr_data;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int hdr_cnt();
        return int'({img[0], img[1]});
    endfunction

    // Expected writes: word w is bytes 2+4w..5+4w, big-endian, at byte address 4w.
    function automatic void model();
        int c = hdr_cnt();
        exp_q.delete();
        if (c >= 1 && c <= 256)
            for (int w = 0; w < c; w++)
                exp_q.push_back({32'(w * 4), img[2+4*w], img[3+4*w], img[4+4*w], img[5+4*w]});
    endfunction

    task automatic build_image(input int cnt, input int nwords);
        img.delete();
        img.push_back(8'(cnt >> 8));
        img.push_back(8'(cnt));
        for (int i = 0; i < nwords * 4; i++) img.push_back(8'($urandom));
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("accept_timeout", 64'(n), 64'(0));
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $fatal(1);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
    endtask

    // Streams img with gmin..gmax idle cycles before each byte; returns on the
    // negedge after the last accept with in_valid dropped.
    task automatic drive_image(input int gmin, input int gmax);
        for (int i = 0; i < img.size(); i++) begin
            int g = $urandom_range(gmax, gmin);
            if (g > 0) begin
                @(negedge clk); bus.in_valid = 1'b0;
                repeat (g - 1) @(negedge clk);
            end
            send_byte(img[i]);
        end
        @(negedge clk); bus.in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        check({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < n; i++)
            check({tag, "_wr"}, {obs_q[i].a, obs_q[i].d}, exp_q[i]);
    endtask

    // Caller has already issued start.
    task automatic run_image(input string tag, input int gmin, input int gmax);
        int a0, c, exp_acc;
        c = hdr_cnt();
        model();
        obs_q.delete();
        a0 = n_acc;
        drive_image(gmin, gmax);
        repeat (3) @(negedge clk);
        exp_acc = (c > 256) ? 2 : img.size();
        check_writes(tag);
        check({tag, "_acc"}, 64'(n_acc - a0), 64'(exp_acc));
        check({tag, "_done"}, 64'(done), 64'(c <= 256));
        check({tag, "_err"}, 64'(error), 64'(c > 256));
        check({tag, "_hold"}, 64'(cpu_hold), 64'(c > 256));
        check({tag, "_rdy"}, 64'(bus.in_ready), 64'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hold"}, 64'(cpu_hold), 64'(1));
        check({tag, "_rdy"}, 64'(bus.in_ready), 64'(0));
        check({tag, "_wren"}, 64'(bus.wr_en), 64'(0));
        check({tag, "_addr"}, 64'(bus.wr_addr), 64'(0));
        check({tag, "_data"}, 64'(bus.wr_data), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_err"}, 64'(error), 64'(0));
    endtask

    initial begin
        int a0, sp, c;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_rdy", 64'(bus.in_ready), 64'(0));

        // Normal two-word load, back-to-back.
        img = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h28, 8'h20, 8'h20, 8'h04, 8'h00, 8'h14};
        model();
        obs_q.delete();
        pulse_start();
        check("norm_hold_loading", 64'(cpu_hold), 64'(1));
        drive_image(0, 0);
        check("norm_wren_final", 64'(bus.wr_en), 64'(1));
        check("norm_done_early", 64'(done), 64'(0));
        @(negedge clk);
        check("norm_done", 64'(done), 64'(1));
        check("norm_hold", 64'(cpu_hold), 64'(0));
        check("norm_wren_off", 64'(bus.wr_en), 64'(0));
        check("norm_addr_hold", 64'(bus.wr_addr), 64'(32'h4));
        repeat (2) @(negedge clk);
        check_writes("norm");
        sp = (obs_q.size() >= 2) ? obs_q[1].c - obs_q[0].c : -1;
        check("norm_spacing", 64'(sp), 64'(4));

        // Empty image.
        img = '{8'h00, 8'h00};
        model();
        obs_q.delete();
        pulse_start();
        drive_image(0, 0);
        check("empty_done", 64'(done), 64'(1));
        check("empty_hold", 64'(cpu_hold), 64'(0));
        check("empty_rdy", 64'(bus.in_ready), 64'(0));
        repeat (3) @(negedge clk);
        check_writes("empty");

        // Oversize image: 257 words, further bytes must not be taken.
        img = '{8'h01, 8'h01};
        model();
        obs_q.delete();
        a0 = n_acc;
        pulse_start();
        drive_image(0, 0);
        check("ovr_err", 64'(error), 64'(1));
        check("ovr_hold", 64'(cpu_hold), 64'(1));
        check("ovr_rdy", 64'(bus.in_ready), 64'(0));
        check("ovr_done", 64'(done), 64'(0));
        bus.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("ovr_acc", 64'(n_acc - a0), 64'(2));
        check_writes("ovr");

        // Backpressure: valid 1,0,0,1,... on a one-word image.
        build_image(1, 1);
        pulse_start();
        run_image("bp", 2, 2);

        // Reset after six data bytes of a three-word image.
        build_image(3, 3);
        model();
        obs_q.delete();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(img[i]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_nwr", 64'(obs_q.size()), 64'(1));
        check("midrst_mem0", 64'(mem[0]), exp_q[0]);
        check("midrst_idle_rdy", 64'(bus.in_ready), 64'(0));
        build_image(2, 2);
        pulse_start();
        run_image("reload", 0, 1);

        // Start during DATA is ignored.
        build_image(1, 1);
        model();
        obs_q.delete();
        a0 = n_acc;
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(img[i]);
        @(negedge clk); bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rs_rdy_idle", 64'(bus.in_ready), 64'(1));
        pulse_start();
        check("rs_rdy_after_start", 64'(bus.in_ready), 64'(1));
        check("rs_err_after_start", 64'(error), 64'(0));
        send_byte(img[4]);
        send_byte(img[5]);
        @(negedge clk); bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_writes("rs_data");
        check("rs_data_acc", 64'(n_acc - a0), 64'(6));
        check("rs_data_done", 64'(done), 64'(1));

        // Start from DONE clears done and reloads at address 0.
        pulse_start();
        check("rs_done_clr", 64'(done), 64'(0));
        check("rs_done_hold", 64'(cpu_hold), 64'(1));
        build_image(1, 1);
        run_image("rs_done", 0, 1);

        // Random images.
        for (int k = 0; k < 6; k++) begin
            c = $urandom_range(12, 1);
            build_image(c, c);
            pulse_start();
            run_image("rnd", 0, 2);
        end

        // Largest accepted image, then a random oversize header.
        build_image(256, 256);
        pulse_start();
        run_image("max", 0, 0);
        c = $urandom_range(65535, 257);
        build_image(c, 0);
        pulse_start();
        run_image("ovr_rnd", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
